bit8_capture_fifo: RTL
======================

Name: bit8_capture_fifo

Overview:
- Downstream capture stage for the 8-bit 2-to-1 mux datapath.
- Each cycle, the 8-bit mux result (`din`) can be written into a small circular FIFO.
- A later consumer (display, ALU operand latch or testbench checker) pops entries in order with a registered read port.
- Provides occupancy, full/empty status and sticky overflow/underflow error flags for lab debug.

Parameters:
- WIDTH, 8, data width in bits; matches the mux output width.
- DEPTH, 4, number of storage entries; must be a power of two, at least 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- wr_en  input  1  write request; pushes din this cycle.
- din  input  WIDTH  data from the 8-bit mux output.
- rd_en  input  1  read request; pops the oldest entry.
- dout  output  WIDTH  registered read data.
- dout_valid  output  1  high for exactly one cycle when dout carries newly popped data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AW+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky; a write was rejected.
- underflow  output  1  sticky; a read was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - dout=0, dout_valid=0, overflow=0, underflow=0.
  - Therefore empty=1, full=0.
  - Storage contents are don't-care and are never observable before being written.
  - Deassertion is sampled at the next rising clk.
- Status outputs: full, empty and count are combinational from the count register. They reflect state after the most recent edge.
- Write acceptance: do_wr = wr_en & (~full | rd_en).
  - When full with a simultaneous read, the write is accepted.
  - Accepted write: mem[wr_ptr] <= din; wr_ptr <= wr_ptr+1 (wraps modulo DEPTH).
- Read acceptance: do_rd = rd_en & ~empty.
  - Accepted read: dout <= mem[rd_ptr]; dout_valid <= 1; rd_ptr <= rd_ptr+1 (wraps modulo DEPTH).
  - Latency is one cycle: data appears on dout the cycle after rd_en is sampled.
- No read: dout_valid <= 0 and dout holds its last value.
- Empty with simultaneous write and read: the read is rejected (no bypass). underflow <= 1, and the write is accepted normally.
- Count update per edge:
  - +1 on do_wr & ~do_rd.
  - -1 on do_rd & ~do_wr.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Full with simultaneous write and read:
  - The read returns the oldest entry; the write stores into the freed slot.
  - count stays at DEPTH and both pointers advance.
- Errors:
  - overflow <= 1 on wr_en & full & ~rd_en.
  - underflow <= 1 on rd_en & empty.
  - Both flags are sticky until reset.
  - A rejected operation changes no pointer, count or storage.
- Pointer wrap: pointers are AW bits and wrap naturally. Full/empty are decided by count only, never by pointer compare.
- Reset mid-operation: all of the above clear asynchronously. Any pop in flight is lost (dout_valid=0 immediately).

Test Plan:
- Reset check: hold reset=0 with random wr_en/rd_en -> count=0, empty=1, full=0, dout=0, dout_valid=0, overflow=0, underflow=0.
- Fill and drain: write 8'hA1, 8'hB2, 8'hC3, 8'hD4 on consecutive cycles -> full=1, count=4. Then read 4 cycles -> dout=A1, B2, C3, D4, each one cycle after its rd_en, with dout_valid high each cycle; finally empty=1.
- Overflow: at full, write 8'hEE with rd_en=0 -> overflow=1, count=4. A subsequent drain returns A1..D4 with EE absent. underflow=0.
- Full with simultaneous write/read: at full, wr_en=1, din=8'h55, rd_en=1 -> dout=oldest entry, count stays 4, overflow=0. Draining afterwards ends with 55.
- Empty with simultaneous write/read: write 8'h3C and read on the same cycle when empty -> underflow=1, dout_valid=0, count=1. The next read returns 3C.
- Wrap and async reset: run 10 write/read pairs of values 0..9 through, with pointers wrapping twice -> outputs 0..9 in order. Then pull reset low between clock edges with count=2 -> count=0 and empty=1 immediately, before the next clk edge.

Source files
------------

// File: rtl/bit8_capture_fifo.sv
// rtl/bit8_capture_fifo.sv - circular capture FIFO for the 8-bit mux result
// Registered read port, count-based full/empty, sticky overflow/underflow flags.
module bit8_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_do_wr;
  logic w_do_rd;

  assign w_full  = (r_count == L_DEPTH);
  assign w_empty = (r_count == '0);
  // A read at full frees a slot in the same edge, so the write may proceed.
  assign w_do_wr = wr_en & (~w_full | rd_en);
  assign w_do_rd = rd_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= w_do_rd;
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en & w_full & ~rd_en) begin
        r_overflow <= 1'b1;
      end
      if (rd_en & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign full       = w_full;
  assign empty      = w_empty;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule
